// File: rtl/blackjack_pkg.sv
// Shared types and sizing helpers for the indicator/pulse blocks of the blackjack table.
// Holds the pulse FSM state encoding and the width helpers used for port and counter sizing.
package blackjack_pkg;

  typedef enum logic [1:0] {
    PS_IDLE = 2'd0,
    PS_HOLD = 2'd1,
    PS_GAP  = 2'd2
  } pulse_state_t;

  // Bits needed to hold 0..max_pending.
  function automatic int pend_width(input int max_pending);
    if (max_pending < 1) return 1;
    return $clog2(max_pending + 1);
  endfunction

  // Bits needed for a down-counter loaded with at most max(hold, gap)-1.
  function automatic int timer_width(input int hold, input int gap);
    int m;
    m = (hold > gap) ? hold : gap;
    if (m < 2) return 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter that stops at zero; zero flags the last cycle of a timed phase.
module cycle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign zero = (r_count == '0);

endmodule

// File: rtl/led_pulse_stretcher.sv
// Turns short event strobes into fixed-length active-low LED pulses separated by a minimum gap;
// events arriving while a pulse or gap is shown are counted and replayed in order.
module led_pulse_stretcher
  import blackjack_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int MAX_PENDING = 3
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in,
  output logic                                out_n,
  output logic                                busy,
  output logic [pend_width(MAX_PENDING)-1:0]  pending,
  output logic                                overflow,
  output logic [1:0]                          o_dbg_state
);

  localparam int PW = pend_width(MAX_PENDING);
  localparam int TW = timer_width(HOLD_CYCLES, GAP_CYCLES);

  localparam logic [PW-1:0] MAX_P     = PW'(MAX_PENDING);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);

  // Handshake: none. 'in' is a free-running level; an event is its rising edge, one per edge.
  // Outputs are plain registered levels with no back-pressure; overflow is a 1-cycle strobe.

  pulse_state_t  r_state;
  logic          r_in_q;
  logic          r_out_n;
  logic          r_busy;
  logic [PW-1:0] r_pending;
  logic          r_overflow;

  pulse_state_t  w_state_nxt;
  logic          w_out_n_nxt;
  logic          w_ev;
  logic          w_timer_zero;
  logic          w_load;
  logic [TW-1:0] w_load_val;
  logic          w_gap_exit;
  logic          w_consume;
  logic          w_enqueue;
  logic [PW-1:0] w_pending_nxt;
  logic          w_overflow_nxt;

  assign w_ev = in & ~r_in_q;

  cycle_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .load_val (w_load_val),
    .zero     (w_timer_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= PS_IDLE;
      r_in_q     <= 1'b1;
      r_out_n    <= 1'b1;
      r_busy     <= 1'b0;
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_q     <= in;
      r_out_n    <= w_out_n_nxt;
      r_busy     <= (w_state_nxt != PS_IDLE);
      r_pending  <= w_pending_nxt;
      r_overflow <= w_overflow_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_out_n_nxt = r_out_n;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_gap_exit  = 1'b0;
    w_consume   = 1'b0;
    case (r_state)
      PS_IDLE: begin
        if (w_ev) begin
          w_state_nxt = PS_HOLD;
          w_out_n_nxt = 1'b0;
          w_load      = 1'b1;
          w_load_val  = HOLD_LOAD;
        end
      end
      PS_HOLD: begin
        if (w_timer_zero) begin
          w_state_nxt = PS_GAP;
          w_out_n_nxt = 1'b1;
          w_load      = 1'b1;
          w_load_val  = GAP_LOAD;
        end
      end
      PS_GAP: begin
        if (w_timer_zero) begin
          w_gap_exit = 1'b1;
          // A queued event takes priority; a fresh edge here is only shown directly if the queue is empty.
          if ((r_pending != '0) || w_ev) begin
            w_state_nxt = PS_HOLD;
            w_out_n_nxt = 1'b0;
            w_load      = 1'b1;
            w_load_val  = HOLD_LOAD;
            w_consume   = (r_pending != '0);
          end else begin
            w_state_nxt = PS_IDLE;
            w_out_n_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = PS_IDLE;
        w_out_n_nxt = 1'b1;
      end
    endcase
  end

  assign w_enqueue = w_ev && (r_state != PS_IDLE) && !(w_gap_exit && (r_pending == '0));

  always_comb begin
    w_pending_nxt  = r_pending;
    w_overflow_nxt = 1'b0;
    if (w_enqueue && !w_consume) begin
      if (r_pending == MAX_P) begin
        w_overflow_nxt = 1'b1;
      end else begin
        w_pending_nxt = r_pending + PW'(1);
      end
    end else if (!w_enqueue && w_consume) begin
      w_pending_nxt = r_pending - PW'(1);
    end
  end

  assign out_n       = r_out_n;
  assign busy        = r_busy;
  assign pending     = r_pending;
  assign overflow    = r_overflow;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Directed bench for led_pulse_stretcher at HOLD=4, GAP=2, MAX_PENDING=3.
module tb_led_pulse_stretcher;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_s;
  logic       out_n;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int lows;
  int falls;
  int ov_cnt;
  logic prev_out;

  typedef struct {
    logic       in_v;
    logic       out_n;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;
  } vec_t;

  vec_t vecs[$];

  led_pulse_stretcher #(
    .HOLD_CYCLES (4),
    .GAP_CYCLES  (2),
    .MAX_PENDING (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in          (in_s),
    .out_n       (out_n),
    .busy        (busy),
    .pending     (pending),
    .overflow    (overflow),
    .o_dbg_state (dbg_state)
  );

  always #50 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic i, input logic o, input logic b, input logic [1:0] p,
                     input logic ov);
    vec_t v;
    v.in_v = i; v.out_n = o; v.busy = b; v.pending = p; v.overflow = ov;
    vecs.push_back(v);
  endtask

  // Drive 'in' at a falling edge, then sample outputs at the next falling edge.
  task automatic cyc(input logic v);
    in_s = v;
    @(negedge clk);
    if (out_n === 1'b0) lows++;
    if (prev_out === 1'b1 && out_n === 1'b0) falls++;
    if (overflow === 1'b1) ov_cnt++;
    prev_out = out_n;
  endtask

  task automatic clr();
    lows = 0; falls = 0; ov_cnt = 0;
    prev_out = out_n;
  endtask

  int exp_p5[16]  = '{0, 0, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3, 3};
  int exp_ov5[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0};

  initial begin
    // single strobe from idle, then one pulse followed by three queued events
    add(0, 1, 0, 0, 0);
    add(1, 0, 1, 0, 0); add(1, 0, 1, 0, 0); add(0, 0, 1, 0, 0); add(0, 0, 1, 0, 0);
    add(0, 1, 1, 0, 0); add(0, 1, 1, 0, 0); add(0, 1, 0, 0, 0); add(0, 1, 0, 0, 0);
    add(1, 0, 1, 0, 0); add(0, 0, 1, 0, 0); add(1, 0, 1, 1, 0); add(0, 0, 1, 1, 0);
    add(1, 1, 1, 2, 0); add(0, 1, 1, 2, 0); add(1, 0, 1, 2, 0); add(0, 0, 1, 2, 0);
    add(0, 0, 1, 2, 0); add(0, 0, 1, 2, 0); add(0, 1, 1, 2, 0); add(0, 1, 1, 2, 0);
    add(0, 0, 1, 1, 0); add(0, 0, 1, 1, 0); add(0, 0, 1, 1, 0); add(0, 0, 1, 1, 0);
    add(0, 1, 1, 1, 0); add(0, 1, 1, 1, 0); add(0, 0, 1, 0, 0); add(0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0); add(0, 0, 1, 0, 0); add(0, 1, 1, 0, 0); add(0, 1, 1, 0, 0);
    add(0, 1, 0, 0, 0); add(0, 1, 0, 0, 0);

    in_s = 1'b1; rst_n = 1'b0; prev_out = 1'b1;
    lows = 0; falls = 0; ov_cnt = 0;
    repeat (2) @(negedge clk);
    chk("reset out_n", out_n, 1);
    chk("reset busy", busy, 0);
    chk("reset pending", pending, 0);
    chk("reset overflow", overflow, 0);
    chk("reset state", dbg_state, 0);
    in_s = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].in_v);
      chk($sformatf("vec%0d out_n", i), out_n, vecs[i].out_n);
      chk($sformatf("vec%0d busy", i), busy, vecs[i].busy);
      chk($sformatf("vec%0d pending", i), pending, vecs[i].pending);
      chk($sformatf("vec%0d overflow", i), overflow, vecs[i].overflow);
    end

    // held-high input is a single event
    clr();
    repeat (20) cyc(1);
    repeat (10) cyc(0);
    chk("held lows", lows, 4);
    chk("held pulses", falls, 1);
    chk("held busy", busy, 0);

    // input already high at reset release is not an event
    rst_n = 1'b0;
    cyc(1); cyc(1);
    rst_n = 1'b1;
    clr();
    repeat (10) cyc(1);
    chk("rel-high lows", lows, 0);
    chk("rel-high busy", busy, 0);
    cyc(0);
    clr();
    cyc(1);
    repeat (12) cyc(0);
    chk("rel-high retrig lows", lows, 4);
    chk("rel-high retrig pulses", falls, 1);

    // burst of events: saturation at 3 and overflow strobes
    clr();
    for (int c = 0; c < 16; c++) begin
      cyc((c % 2 == 0) ? 1'b1 : 1'b0);
      chk($sformatf("burst pending c%0d", c), pending, exp_p5[c]);
      chk($sformatf("burst overflow c%0d", c), overflow, exp_ov5[c]);
    end
    repeat (30) cyc(0);
    chk("burst pulses", falls, 6);
    chk("burst ov cycles", ov_cnt, 2);
    chk("burst busy end", busy, 0);
    chk("burst pending end", pending, 0);

    // event on the last gap cycle with an empty queue
    clr();
    cyc(1);
    repeat (3) cyc(0);
    chk("lastgap hold end", out_n, 0);
    cyc(0);
    chk("lastgap gap1", out_n, 1);
    cyc(0);
    chk("lastgap gap2", out_n, 1);
    cyc(1);
    chk("lastgap rehold", out_n, 0);
    chk("lastgap pending", pending, 0);
    chk("lastgap busy", busy, 1);
    repeat (12) cyc(0);
    chk("lastgap lows", lows, 8);
    chk("lastgap pulses", falls, 2);

    // asynchronous reset mid-hold with two events queued
    clr();
    cyc(1); cyc(0); cyc(1); cyc(0); cyc(1); cyc(0); cyc(1); cyc(0);
    chk("midrst pre pending", pending, 2);
    chk("midrst pre out_n", out_n, 0);
    #20 rst_n = 1'b0;
    #1;
    chk("midrst out_n", out_n, 1);
    chk("midrst pending", pending, 0);
    chk("midrst busy", busy, 0);
    chk("midrst state", dbg_state, 0);
    @(negedge clk);
    in_s = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clr();
    repeat (12) cyc(0);
    chk("midrst quiet lows", lows, 0);
    chk("midrst quiet pulses", falls, 0);
    cyc(1);
    repeat (10) cyc(0);
    chk("midrst new pulses", falls, 1);
    chk("midrst new lows", lows, 4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
